mips_instr_encoder: RTL

- Inverse of the mini-MIPS control decoder: packs an instruction ID plus operand fields into a 32-bit MIPS instruction word, using the same op/func encodings the decoder consumes.
- Feeds test-program generators and boot ROM loaders.
- Valid/ready input and output, DEPTH-entry output FIFO, issued-word counter and sticky error flag.

---
 rtl/mips_isa_pkg.sv | 90 +++++++++
 rtl/mips_enc_pack.sv | 83 ++++++++
 rtl/mips_instr_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: opcode/func encodings, instruction IDs and format helpers
// shared by the mini-MIPS encoder. The encodings match the ones the control
// decoder consumes.
package mips_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  localparam int unsigned ID_LAST = 21;

  typedef enum logic [4:0] {
    ID_LUI     = 5'd0,
    ID_ADD     = 5'd1,
    ID_SUB     = 5'd2,
    ID_SLT     = 5'd3,
    ID_ADDI    = 5'd4,
    ID_SLTI    = 5'd5,
    ID_AND     = 5'd6,
    ID_OR      = 5'd7,
    ID_XOR     = 5'd8,
    ID_NOR     = 5'd9,
    ID_ANDI    = 5'd10,
    ID_ORI     = 5'd11,
    ID_XORI    = 5'd12,
    ID_LW      = 5'd13,
    ID_SW      = 5'd14,
    ID_J       = 5'd15,
    ID_JR      = 5'd16,
    ID_BLTZ    = 5'd17,
    ID_BEQ     = 5'd18,
    ID_BNE     = 5'd19,
    ID_JAL     = 5'd20,
    ID_SYSCALL = 5'd21
  } instr_id_t;

  // Word layouts
  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_t;

  // True for instructions that write a general register through rd or rt.
  // JAL is left out: its destination is hard-wired to $31.
  function automatic logic is_reg_write(input instr_id_t id);
    case (id)
      ID_ADD, ID_SUB, ID_SLT, ID_AND, ID_OR, ID_XOR, ID_NOR,
      ID_LUI, ID_ADDI, ID_SLTI, ID_ANDI, ID_ORI, ID_XORI, ID_LW:
        is_reg_write = 1'b1;
      default:
        is_reg_write = 1'b0;
    endcase
  endfunction

  // True when the destination register is carried in rd (R-type writers);
  // otherwise it is carried in rt.
  function automatic logic dest_is_rd(input instr_id_t id);
    case (id)
      ID_ADD, ID_SUB, ID_SLT, ID_AND, ID_OR, ID_XOR, ID_NOR:
        dest_is_rd = 1'b1;
      default:
        dest_is_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_enc_pack.sv
// mips_enc_pack: combinational field packer. Turns an instruction ID plus
// operand fields into a 32-bit word; id_valid drops for unknown IDs.
// Optional build macro MIPS_ENC_ZEROREG_CHK_EN also rejects register writers
// whose destination is $0.
module mips_enc_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  id,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] instr,
  output logic        id_valid
);

  instr_id_t  id_e;
  fmt_t       fmt;
  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rs_f;
  logic [4:0] rt_f;
  logic [4:0] rd_f;

  assign id_e = instr_id_t'(id);

  // Select format, opcode/func and zero the fields each instruction ignores
  always_comb begin
    fmt      = FMT_R;
    op       = OP_RTYPE;
    func     = 6'b000000;
    rs_f     = rs;
    rt_f     = rt;
    rd_f     = rd;
    id_valid = 1'b1;
    instr    = 32'h0;

    case (id_e)
      ID_LUI:     begin fmt = FMT_I; op = OP_LUI; rs_f = 5'd0; end
      ID_ADD:     func = FN_ADD;
      ID_SUB:     func = FN_SUB;
      ID_SLT:     func = FN_SLT;
      ID_AND:     func = FN_AND;
      ID_OR:      func = FN_OR;
      ID_XOR:     func = FN_XOR;
      ID_NOR:     func = FN_NOR;
      ID_ADDI:    begin fmt = FMT_I; op = OP_ADDI; end
      ID_SLTI:    begin fmt = FMT_I; op = OP_SLTI; end
      ID_ANDI:    begin fmt = FMT_I; op = OP_ANDI; end
      ID_ORI:     begin fmt = FMT_I; op = OP_ORI;  end
      ID_XORI:    begin fmt = FMT_I; op = OP_XORI; end
      ID_LW:      begin fmt = FMT_I; op = OP_LW;   end
      ID_SW:      begin fmt = FMT_I; op = OP_SW;   end
      ID_BEQ:     begin fmt = FMT_I; op = OP_BEQ;  end
      ID_BNE:     begin fmt = FMT_I; op = OP_BNE;  end
      ID_BLTZ:    begin fmt = FMT_I; op = OP_BLTZ; rt_f = 5'd0; end
      ID_J:       begin fmt = FMT_J; op = OP_J;    end
      ID_JAL:     begin fmt = FMT_J; op = OP_JAL;  end
      ID_JR:      begin func = FN_JR; rt_f = 5'd0; rd_f = 5'd0; end
      ID_SYSCALL: begin func = FN_SYSCALL; rs_f = 5'd0; rt_f = 5'd0; rd_f = 5'd0; end
      default:    id_valid = 1'b0;
    endcase

`ifdef MIPS_ENC_ZEROREG_CHK_EN
    if (id_valid && is_reg_write(id_e)) begin
      if (dest_is_rd(id_e) ? (rd == 5'd0) : (rt == 5'd0)) begin
        id_valid = 1'b0;
      end
    end
`endif

    case (fmt)
      FMT_R:   instr = {op, rs_f, rt_f, rd_f, 5'b00000, func};
      FMT_I:   instr = {op, rs_f, rt_f, imm[15:0]};
      default: instr = {op, imm};
    endcase

    if (!id_valid) begin
      instr = 32'h0;
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: valid/ready front end around mips_enc_pack with a
// DEPTH-entry output FIFO, issued-word counter and error flags.
// Optional build macro MIPS_ENC_ZEROREG_CHK_EN (handled in mips_enc_pack).
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_id,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [25:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      instr_p0;
  logic             id_valid_p0;
  logic             push_hs;
  logic             wr_en;
  logic             pop_hs;
  logic             full;
  logic             empty;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [31:0]      mem [DEPTH];
  logic             err_p1;

  mips_enc_pack u_pack (
    .id       (in_id),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .imm      (in_imm),
    .instr    (instr_p0),
    .id_valid (id_valid_p0)
  );

  // Pointer compare: equal index with differing wrap bit means full
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_instr = empty ? 32'h0 : mem[rptr[AW-1:0]];

  assign push_hs = in_valid && in_ready;
  assign wr_en   = push_hs && id_valid_p0;
  assign pop_hs  = out_valid && out_ready;

  // ---- stage p0 -> p1: FIFO storage (data only, no reset) ----
  // Write the packed word into the slot addressed by the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= instr_p0;
    end
  end

  // Advance FIFO pointers on accepted writes and output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop_hs) begin
        rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Count words handed to the consumer; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
    end else if (pop_hs) begin
      issued_cnt <= issued_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Flag a consumed request whose ID could not be encoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1     <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_p1 <= push_hs && !id_valid_p0;
      if (push_hs && !id_valid_p0) begin
        err_sticky <= 1'b1;
      end
    end
  end

  assign err_pulse = err_p1;

endmodule
